fifo_rx: RTL and testbench

Receive-side byte FIFO of the UART: it buffers bytes delivered by the UART receiver until the host reads them, and mirrors the transmit FIFO on the TX path. Writes come from the receiver as single-cycle frame strobes. Reads come from the host with a read-enable handshake and a registered data output. Overflow is detected and latched, and an almost-full flag supports flow control.

---
 rtl/uart_fifo_pkg.sv | 18 +
 rtl/fifo_rx_mem.sv | 34 +++
 rtl/fifo_rx.sv | 93 +++++++++
 tb/tb_fifo_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: sizing constants shared by the UART RX and TX byte FIFOs.
//   DATA_W    byte width
//   DEPTH     FIFO entries (power of two)
//   ADDR_W    log2(DEPTH), pointer width
//   AFULL_LVL occupancy at or above which almost_full asserts
//   MEM_W     stored entry width; one extra error-tag bit when
//             FIFO_RX_ERR_TAG_EN is defined
package uart_fifo_pkg;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int ADDR_W    = 4;
    localparam int AFULL_LVL = 12;
`ifdef FIFO_RX_ERR_TAG_EN
    localparam int MEM_W     = DATA_W + 1;
`else
    localparam int MEM_W     = DATA_W;
`endif
endpackage

// File: rtl/fifo_rx_mem.sv
// fifo_rx_mem: simple dual-port storage for the RX FIFO.
//   clk_fifo_rx  clock
//   rst_fifo_rx  async active-high reset (read register only; array is not reset)
//   wr_en/wr_addr/wr_data  synchronous write port
//   rd_en/rd_addr          read request; rd_data is registered and holds
//                          its value when rd_en is low
// Entry width is MEM_W, which grows by one bit under FIFO_RX_ERR_TAG_EN.
module fifo_rx_mem
    import uart_fifo_pkg::*;
(
    input  logic              clk_fifo_rx,
    input  logic              rst_fifo_rx,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [MEM_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [MEM_W-1:0]  rd_data
);

    logic [MEM_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_fifo_rx) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // A write and a read to the same slot (only possible when full) returns
    // the old contents: the read samples before the write lands.
    always_ff @(posedge clk_fifo_rx or posedge rst_fifo_rx) begin
        if (rst_fifo_rx)  rd_data <= '0;
        else if (rd_en)   rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo_rx.sv
// fifo_rx: UART receive-side byte FIFO.
//   clk_fifo_rx, rst_fifo_rx   clock, async active-high reset
//   data_in, frame_valid       received byte + one-cycle strobe
//   frame_err                  per-byte error tag (stored only with
//                              FIFO_RX_ERR_TAG_EN defined)
//   rd_en                      host read request
//   clr_overrun                clears sticky overrun
//   data_out, data_valid       registered read data + one-cycle pulse
//   data_err                   error tag of data_out (0 without the macro)
//   empty, full, almost_full   flags decoded from registered count
//   count                      occupancy 0..DEPTH
//   overrun                    sticky: a byte was dropped while full
// Configuration macro: FIFO_RX_ERR_TAG_EN.
module fifo_rx
    import uart_fifo_pkg::*;
(
    input  logic              clk_fifo_rx,
    input  logic              rst_fifo_rx,
    input  logic [DATA_W-1:0] data_in,
    input  logic              frame_valid,
    input  logic              frame_err,
    input  logic              rd_en,
    input  logic              clr_overrun,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              data_err,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overrun
);

    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);

    logic [ADDR_W-1:0] wr_pt, rd_pt;
    logic              rd_acc, wr_acc, wr_drop;
    logic [MEM_W-1:0]  wr_word, rd_word;

    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign almost_full = (count >= AFULL_CNT);

    // Full + read frees a slot in the same cycle, so the write is taken too.
    // Empty + write does not bypass: the read is simply ignored.
    assign rd_acc  = rd_en && !empty;
    assign wr_acc  = frame_valid && (!full || rd_en);
    assign wr_drop = frame_valid && full && !rd_en;

`ifdef FIFO_RX_ERR_TAG_EN
    assign wr_word  = {frame_err, data_in};
    assign data_out = rd_word[DATA_W-1:0];
    assign data_err = rd_word[DATA_W];
`else
    logic unused_frame_err;
    assign unused_frame_err = frame_err;
    assign wr_word  = data_in;
    assign data_out = rd_word;
    assign data_err = 1'b0;
`endif

    fifo_rx_mem u_mem (
        .clk_fifo_rx (clk_fifo_rx),
        .rst_fifo_rx (rst_fifo_rx),
        .wr_en       (wr_acc),
        .wr_addr     (wr_pt),
        .wr_data     (wr_word),
        .rd_en       (rd_acc),
        .rd_addr     (rd_pt),
        .rd_data     (rd_word)
    );

    always_ff @(posedge clk_fifo_rx or posedge rst_fifo_rx) begin
        if (rst_fifo_rx) begin
            wr_pt      <= '0;
            rd_pt      <= '0;
            count      <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            if (wr_acc) wr_pt <= wr_pt + ADDR_W'(1);
            if (rd_acc) rd_pt <= rd_pt + ADDR_W'(1);
            if (wr_acc && !rd_acc)      count <= count + (ADDR_W+1)'(1);
            else if (rd_acc && !wr_acc) count <= count - (ADDR_W+1)'(1);
            // A drop in the same cycle as a clear keeps the flag set.
            if (wr_drop)          overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rx.sv
// tb_fifo_rx: self-checking bench for fifo_rx. A queue-based reference
// model tracks contents and expected outputs; a vector table plus directed
// sequences cover the listed corner cases, followed by random traffic.
module tb_fifo_rx;
    import uart_fifo_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] data_in = '0;
    logic              frame_valid = 1'b0;
    logic              frame_err = 1'b0;
    logic              rd_en = 1'b0;
    logic              clr_overrun = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid, data_err, empty, full, almost_full, overrun;
    logic [ADDR_W:0]   count;

    always #5 clk = ~clk;

    fifo_rx dut (
        .clk_fifo_rx (clk),
        .rst_fifo_rx (rst),
        .data_in     (data_in),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .rd_en       (rd_en),
        .clr_overrun (clr_overrun),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_err    (data_err),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overrun     (overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [8:0] q[$];
    logic [7:0] m_dout = '0;
    logic       m_dv = 1'b0, m_err = 1'b0, m_ovr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic fv, input logic [7:0] d, input logic fe,
                              input logic rd, input logic clr);
        logic [8:0] w;
        logic       dropped;
        m_dv = rd && (q.size() != 0);
        if (m_dv) begin
            w = q.pop_front();
            m_dout = w[7:0];
`ifdef FIFO_RX_ERR_TAG_EN
            m_err = w[8];
`else
            m_err = 1'b0;
`endif
        end
        dropped = 1'b0;
        if (fv) begin
            if (q.size() < DEPTH) q.push_back({fe, d});
            else dropped = 1'b1;
        end
        if (dropped)  m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data_valid"},  data_valid,  m_dv);
        chk({tag, ".data_out"},    data_out,    m_dout);
        chk({tag, ".data_err"},    data_err,    m_err);
        chk({tag, ".count"},       count,       q.size());
        chk({tag, ".empty"},       empty,       q.size() == 0);
        chk({tag, ".full"},        full,        q.size() == DEPTH);
        chk({tag, ".almost_full"}, almost_full, q.size() >= AFULL_LVL);
        chk({tag, ".overrun"},     overrun,     m_ovr);
    endtask

    task automatic step(input string tag, input logic fv, input logic [7:0] d,
                        input logic fe, input logic rd, input logic clr);
        frame_valid = fv; data_in = d; frame_err = fe; rd_en = rd; clr_overrun = clr;
        @(posedge clk);
        #1;
        model_step(fv, d, fe, rd, clr);
        check_all(tag);
        frame_valid = 1'b0; frame_err = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
    endtask

    // Asserted away from a clock edge: outputs must clear before any edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, ".rst_count"},   count,      0);
        chk({tag, ".rst_empty"},   empty,      1);
        chk({tag, ".rst_full"},    full,       0);
        chk({tag, ".rst_afull"},   almost_full, 0);
        chk({tag, ".rst_overrun"}, overrun,    0);
        chk({tag, ".rst_dvalid"},  data_valid, 0);
        chk({tag, ".rst_dout"},    data_out,   0);
        chk({tag, ".rst_derr"},    data_err,   0);
        q.delete();
        m_dout = '0; m_dv = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic       fv;
        logic [7:0] d;
        logic       rd;
        logic       exp_dv;
        logic [7:0] exp_dout;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [7:0] exp_b;
        logic       exp_e;

        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1};
        tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 2};
        tbl[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 8'h00, 3};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 2};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h43, 0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h43, 0};  // read while empty
        tbl[7] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h43, 1};  // write+read on empty
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 0};

        repeat (2) @(posedge clk);
        #1;
        do_reset("init");

        for (int i = 0; i < 9; i++) begin
            step($sformatf("vec%0d", i), tbl[i].fv, tbl[i].d, 1'b0, tbl[i].rd, 1'b0);
            chk($sformatf("vec%0d.tbl_dv", i),   data_valid, tbl[i].exp_dv);
            chk($sformatf("vec%0d.tbl_dout", i), data_out,   tbl[i].exp_dout);
            chk($sformatf("vec%0d.tbl_cnt", i),  count,      tbl[i].exp_cnt);
        end

        // fill, almost_full threshold, overrun, clear priority
        for (int i = 0; i < 16; i++) begin
            step($sformatf("fill%0d", i), 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 10) chk("fill.afull_at11", almost_full, 0);
            if (i == 11) chk("fill.afull_at12", almost_full, 1);
        end
        chk("fill.full", full, 1);
        step("drop", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("drop.overrun", overrun, 1);
        chk("drop.count", count, 16);
        step("drop_clr", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("drop_clr.set_wins", overrun, 1);
        step("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr.overrun", overrun, 0);

        // simultaneous write+read while full
        step("fullrw", 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        chk("fullrw.dout", data_out, 8'h00);
        chk("fullrw.count", count, 16);
        chk("fullrw.overrun", overrun, 0);
        for (int i = 0; i < 16; i++) begin
            step($sformatf("drain%0d", i), 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            exp_b = (i == 15) ? 8'hAA : 8'(i + 1);
            chk($sformatf("drain%0d.dout", i), data_out, exp_b);
        end
        chk("drain.empty", empty, 1);

        // pointer wrap-around
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++)
                step($sformatf("wrap%0d_w%0d", r, i), 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 10; i++)
                step($sformatf("wrap%0d_r%0d", r, i), 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end

        // reset mid-operation with overrun set
        for (int i = 0; i < 17; i++)
            step($sformatf("prerst%0d", i), 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        chk("prerst.overrun", overrun, 1);
        do_reset("midrst");

        // error tag
        step("tag_w1", 1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
        step("tag_w2", 1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
`ifdef FIFO_RX_ERR_TAG_EN
        exp_e = 1'b1;
`else
        exp_e = 1'b0;
`endif
        step("tag_r1", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("tag_r1.dout", data_out, 8'h12);
        chk("tag_r1.derr", data_err, exp_e);
        step("tag_r2", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("tag_r2.dout", data_out, 8'h34);
        chk("tag_r2.derr", data_err, 0);

        // random traffic against the model
        for (int i = 0; i < 600; i++)
            step($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
